axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master_if.sv | 76 +++++++
 rtl/axi_burst_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 master-side channel bundle for the burst master: AR, R, AW, W and B channels.
// The master modport drives addresses, write data and ready signals; the slave modport is the mirror image.
interface axi_burst_master_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Read address channel
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // Write address channel
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  // Write data channel
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  // Write response channel
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Simple AXI4 master: turns one request into a single read, a BURST_LEN-beat line refill, or a single write.
// Read beats and the write response are forwarded to the response port combinationally.
module axi_burst_master #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ID_VAL    = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_burst,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,

  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,

  axi_burst_master_if.master    axi
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned SIZE       = $clog2(STRB_W);
  localparam int unsigned LINE_BYTES = BURST_LEN * STRB_W;
  localparam int unsigned CNT_W      = $clog2(BURST_LEN) + 1;
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                lat_write;
  logic                lat_burst;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  logic                aw_done;
  logic                w_done;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    exp_beats;

  assign exp_beats = lat_burst ? CNT_W'(BURST_LEN) : CNT_W'(1);

  // Channel payloads come straight from the latched request, so they read 0 under reset.
  assign axi.arid    = ID_W'(ID_VAL);
  assign axi.araddr  = lat_burst ? (lat_addr & ~ADDR_W'(LINE_BYTES - 1))
                                 : (lat_addr & ~ADDR_W'(STRB_W - 1));
  assign axi.arlen   = lat_burst ? 8'(BURST_LEN - 1) : 8'd0;
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = BURST_INCR;

  assign axi.awid    = ID_W'(ID_VAL);
  assign axi.awaddr  = lat_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'(SIZE);
  assign axi.awburst = BURST_INCR;

  assign axi.wdata   = lat_wdata;
  assign axi.wstrb   = lat_wstrb;

  // IDs, the low response bit and the write flag have no further use once decoded.
  logic unused_sink;
  assign unused_sink = ^{axi.rid, axi.bid, axi.rresp[0], axi.bresp[0], lat_write};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and channel control
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_last    = 1'b0;
    rsp_err     = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_write ? WADDR : RADDR;
        end
      end

      RADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_nxt = RDATA;
        end
      end

      RDATA: begin
        axi.rready = 1'b1;
        rsp_valid  = axi.rvalid;
        rsp_data   = axi.rdata;
        rsp_last   = axi.rlast;
        // An RLAST that arrives on the wrong beat count is reported as an error on that beat.
        rsp_err    = axi.rresp[1] |
                     (axi.rlast & ((beat_cnt + CNT_W'(1)) != exp_beats));
        if (axi.rvalid && axi.rlast) begin
          state_nxt = IDLE;
        end
      end

      WADDR: begin
        axi.awvalid = ~aw_done;
        axi.wvalid  = ~w_done;
        axi.wlast   = 1'b1;
        if ((aw_done || axi.awready) && (w_done || axi.wready)) begin
          state_nxt = WRESP;
        end else if (!aw_done && axi.awready) begin
          state_nxt = WDATA;
        end
      end

      WDATA: begin
        axi.wvalid = 1'b1;
        axi.wlast  = 1'b1;
        if (axi.wready) begin
          state_nxt = WRESP;
        end
      end

      WRESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          rsp_valid = 1'b1;
          rsp_last  = 1'b1;
          rsp_err   = axi.bresp[1];
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, write handshake tracking and read beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_burst <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_burst <= req_burst;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end

      if (state == WADDR) begin
        if (!aw_done && axi.awready) begin
          aw_done <= 1'b1;
        end
        if (!w_done && axi.wready) begin
          w_done <= 1'b1;
        end
      end

      if (state == WDATA && axi.wready) begin
        w_done <= 1'b1;
      end

      if (state == RADDR && axi.arready) begin
        beat_cnt <= '0;
      end else if (state == RDATA && axi.rvalid) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed and randomized bench for axi_burst_master acting as a simple AXI slave.
// Expected channel values and responses come from a transaction-level model of the request rules.
module tb_axi_burst_master;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BL     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_burst_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_burst_master #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .ID_VAL(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = '0;
    axi.rid     = '0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, axi.arvalid, 1'b0);
    check({tag, "_awvalid"}, axi.awvalid, 1'b0);
    check({tag, "_wvalid"},  axi.wvalid,  1'b0);
    check({tag, "_rready"},  axi.rready,  1'b0);
    check({tag, "_bready"},  axi.bready,  1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic burst, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    #1 check("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_burst = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  // last_beat>0 makes the slave end early; err_beat flags one beat with SLVERR; abort_after>0 resets mid-burst.
  task automatic do_read(input logic [31:0] addr, input logic burst, input int ar_delay,
                         input int last_beat, input int err_beat, input int abort_after,
                         input int gap_max);
    int          exp_len;
    int          nb;
    logic [31:0] exp_addr;
    logic [31:0] d;
    logic        lst;
    logic [1:0]  rr;
    exp_len  = burst ? int'(BL) : 1;
    exp_addr = burst ? (addr & ~32'(BL * 4 - 1)) : (addr & ~32'h3);
    nb       = (last_beat > 0) ? last_beat : exp_len;

    issue(1'b0, burst, addr, $urandom, 4'hf);
    for (int c = 0; c <= ar_delay; c++) begin
      axi.arready = (c == ar_delay);
      #1;
      check("ar_valid",  axi.arvalid, 1'b1);
      check("ar_addr",   axi.araddr,  exp_addr);
      check("ar_len",    axi.arlen,   8'(exp_len - 1));
      check("ar_size",   axi.arsize,  3'd2);
      check("ar_burst",  axi.arburst, 2'b01);
      check("ar_rready", axi.rready,  1'b0);
      check("ar_req_rdy", req_ready,  1'b0);
      check("ar_rsp_vld", rsp_valid,  1'b0);
      @(negedge clk);
    end
    axi.arready = 1'b0;
    #1;
    check("rd_arvalid_drop", axi.arvalid, 1'b0);

    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        axi.rvalid = 1'b0;
        #1;
        check("rd_gap_rready", axi.rready, 1'b1);
        check("rd_gap_rsp",    rsp_valid,  1'b0);
        @(negedge clk);
      end
      d   = $urandom;
      lst = (i == nb - 1);
      rr  = (i == err_beat) ? 2'b10 : 2'($urandom_range(0, 1));
      axi.rvalid = 1'b1;
      axi.rdata  = d;
      axi.rlast  = lst;
      axi.rresp  = rr;
      axi.rid    = 4'($urandom);
      #1;
      check("rd_rsp_valid", rsp_valid, 1'b1);
      check("rd_rsp_data",  rsp_data,  d);
      check("rd_rsp_last",  rsp_last,  lst);
      check("rd_rsp_err",   rsp_err,   rr[1] | (lst && (i + 1) != exp_len));
      @(negedge clk);
      if (abort_after > 0 && i + 1 == abort_after) begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rst = 1'b1;
        #1;
        check_quiet("abort");
        check("abort_rsp_last", rsp_last,   1'b0);
        check("abort_rsp_err",  rsp_err,    1'b0);
        check("abort_araddr",   axi.araddr, 32'h0);
        check("abort_wdata",    axi.wdata,  32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("abort_req_ready", req_ready, 1'b1);
        return;
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    #1;
    check("rd_done_req_ready", req_ready,  1'b1);
    check("rd_done_rsp_valid", rsp_valid,  1'b0);
    check("rd_done_rready",    axi.rready, 1'b0);
  endtask

  // AWREADY/WREADY rise aw_delay/w_delay cycles into the write; each VALID must drop after its own handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int aw_delay, input int w_delay, input int b_delay,
                          input logic [1:0] bresp);
    bit aw_seen;
    bit w_seen;
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    issue(1'b1, 1'($urandom), addr, wdata, wstrb);
    for (int t = 0; t < 40 && !(aw_seen && w_seen); t++) begin
      axi.awready = (t >= aw_delay);
      axi.wready  = (t >= w_delay);
      #1;
      check("wr_awvalid", axi.awvalid, !aw_seen);
      check("wr_wvalid",  axi.wvalid,  !w_seen);
      check("wr_awaddr",  axi.awaddr,  addr);
      check("wr_awlen",   axi.awlen,   8'd0);
      check("wr_awsize",  axi.awsize,  3'd2);
      check("wr_awburst", axi.awburst, 2'b01);
      check("wr_wdata",   axi.wdata,   wdata);
      check("wr_wstrb",   axi.wstrb,   wstrb);
      if (!w_seen) check("wr_wlast", axi.wlast, 1'b1);
      check("wr_bready",  axi.bready,  1'b0);
      check("wr_arvalid", axi.arvalid, 1'b0);
      check("wr_rsp",     rsp_valid,   1'b0);
      if (!aw_seen && t >= aw_delay) aw_seen = 1'b1;
      if (!w_seen && t >= w_delay)   w_seen  = 1'b1;
      @(negedge clk);
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    repeat (b_delay) begin
      #1;
      check("wr_b_bready",  axi.bready,  1'b1);
      check("wr_b_awvalid", axi.awvalid, 1'b0);
      check("wr_b_wvalid",  axi.wvalid,  1'b0);
      check("wr_b_rsp",     rsp_valid,   1'b0);
      @(negedge clk);
    end
    axi.bvalid = 1'b1;
    axi.bresp  = bresp;
    axi.bid    = 4'($urandom);
    #1;
    check("wr_b_bready",   axi.bready, 1'b1);
    check("wr_rsp_valid",  rsp_valid,  1'b1);
    check("wr_rsp_last",   rsp_last,   1'b1);
    check("wr_rsp_data",   rsp_data,   32'h0);
    check("wr_rsp_err",    rsp_err,    bresp[1]);
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    check("wr_done_req_ready", req_ready,  1'b1);
    check("wr_done_rsp",       rsp_valid,  1'b0);
    check("wr_done_bready",    axi.bready, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_burst = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    slave_idle();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_rsp_last", rsp_last,   1'b0);
    check("reset_rsp_err",  rsp_err,    1'b0);
    check("reset_araddr",   axi.araddr, 32'h0);
    check("reset_awaddr",   axi.awaddr, 32'h0);
    check("reset_wdata",    axi.wdata,  32'h0);
    check("reset_wstrb",    axi.wstrb,  4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("post_reset_req_ready", req_ready, 1'b1);

    // Burst read at 0x1004
    do_read(32'h1004, 1'b1, 1, 0, -1, 0, 1);
    // Single write with AWREADY three cycles after WREADY
    do_write(32'h2000, 32'hDEADBEEF, 4'b0011, 3, 0, 2, 2'b00);
    // AW and W together in the first cycle
    do_write($urandom, $urandom, 4'($urandom), 0, 0, 0, 2'b00);
    // AW before W
    do_write($urandom, $urandom, 4'($urandom), 0, 2, 1, 2'b00);
    // Early RLAST on beat 2
    do_read(32'h3010, 1'b1, 0, 2, -1, 0, 0);
    // Error responses
    do_write(32'h4000, 32'h12345678, 4'hf, 1, 1, 0, 2'b10);
    do_read(32'h5008, 1'b1, 0, 0, 1, 0, 1);
    // Single reads, aligned and unaligned
    do_read(32'h6003, 1'b0, 2, 0, -1, 0, 2);
    do_read(32'h6000, 1'b0, 0, 0, 0, 0, 0);
    // Reset after beat 2 of 4, then a normal read
    do_read(32'h7000, 1'b1, 0, 0, -1, 2, 0);
    do_read(32'h7040, 1'b1, 1, 0, -1, 0, 1);

    // Randomized mix
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), 2'($urandom));
      end else begin
        do_read($urandom, 1'($urandom), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, BL) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, BL - 1) : -1,
                0, 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
